// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states, byte enables.
// Define LSU_MISALIGN_TRAP_EN to make misaligned half/word accesses illegal.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_MISALIGN = 1'b1;
`else
  localparam bit TRAP_MISALIGN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;

  function automatic logic access_illegal(input logic we, input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic bad_code;
    logic misaligned;
    if (we) bad_code = !(funct3 inside {F3_B, F3_H, F3_W});
    else    bad_code = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return bad_code || (TRAP_MISALIGN && misaligned);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword lane of a memory word and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h000000, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0000, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit: request handshake to data memory, lane steering, error response.
// Misaligned-access trapping is controlled by LSU_MISALIGN_TRAP_EN (see lsu_pkg).
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              we_q, err_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;
  logic [31:0]       load_data;
  logic [3:0]        be_lane;
  logic              accept, illegal;

  assign accept  = (state_q == IDLE) && req_valid;
  assign illegal = access_illegal(req_we, req_funct3, req_addr[1:0]);

  lsu_load_align u_load_align (
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_q[1:0]),
    .rdata_i   (mem_rdata),
    .data_o    (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = illegal ? RESP : REQ;
      REQ:     if (mem_gnt) state_d = we_q ? RESP : WAIT;
      WAIT:    if (mem_rvalid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Misaligned halfwords fall onto their aligned lane pair because only addr[1] is used.
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   begin be_lane = BE_BYTE << addr_q[1:0];         mem_wdata = {4{wdata_q[7:0]}};  end
      2'b01:   begin be_lane = BE_HALF << {addr_q[1], 1'b0};   mem_wdata = {2{wdata_q[15:0]}}; end
      default: begin be_lane = BE_WORD;                        mem_wdata = wdata_q;            end
    endcase
  end

  assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = BE_NONE;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'h0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      REQ: begin
        mem_req = 1'b1;
        mem_we  = we_q;
        mem_be  = be_lane;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = err_q ? 32'h0 : rdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        err_q    <= illegal;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rdata_q  <= 32'h0;
      end
      if ((state_q == WAIT) && mem_rvalid) rdata_q <= load_data;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized scoreboard bench for lsu: driver queues expected memory commands and responses,
// a memory responder and a response monitor check them independently.
`timescale 1ns/1ps
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          gd;
    int          rd;
    logic [31:0] rdata;
  } cmd_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    time         due;
  } exp_t;

  cmd_t cmd_q[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // ---------------- reference model ----------------
  function automatic bit m_illegal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int size;
    bit trap;
    bit bad;
    size = 1 << f3[1:0];
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = 1'b1;
`endif
    bad = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (trap && size > 1 && (addr % size) != 0) bad = 1'b1;
    return bad;
  endfunction

  function automatic int m_off(input logic [2:0] f3, input logic [31:0] addr);
    int size;
    size = 1 << f3[1:0];
    return ((addr % 4) / size) * size;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int size;
    size = 1 << f3[1:0];
    return 4'(((1 << size) - 1) << m_off(f3, addr));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int size;
    logic [31:0] r;
    size = 1 << f3[1:0];
    r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % size) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * m_off(f3, addr));
    case (f3)
      3'd0:    return {{24{v[7]}}, v[7:0]};
      3'd4:    return {24'h0, v[7:0]};
      3'd1:    return {{16{v[15]}}, v[15:0]};
      3'd5:    return {16'h0, v[15:0]};
      default: return rdata;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int gd, input int rd,
                     input logic [31:0] mdata, input bit abandon);
    cmd_t c;
    exp_t e;
    bit   bad;
    int   n;
    bad = m_illegal(we, f3, addr);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL ready_timeout got req_ready=0 expected 1 within 50 cycles");
      return;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    if (!bad) begin
      c.we = we; c.addr = addr & 32'hFFFF_FFFC; c.be = m_be(f3, addr);
      c.wdata = m_wdata(f3, wdata); c.gd = gd; c.rd = rd; c.rdata = mdata;
      cmd_q.push_back(c);
    end
    e.err   = bad;
    e.rdata = (bad || we) ? 32'h0 : m_load(f3, addr, mdata);
    e.due   = $time + 10 * (bad ? 1 : (we ? 2 + gd : 2 + gd + rd));
    if (!abandon) exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (!abandon) begin
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (!req_ready) begin
        failures++;
        $display("FAIL done_timeout got req_ready=0 expected 1 within 50 cycles");
      end
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    cmd_t        cur;
    bit          busy, rv_pend, have;
    int          cnt, rvc;
    logic [31:0] rv_data;
    busy = 0; rv_pend = 0; have = 0; cnt = 0; rvc = 0; rv_data = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    cur = '{we: 1'b1, addr: 0, be: 0, wdata: 0, gd: 0, rd: 1, rdata: 0};
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (!rst_n) busy = 0;
      if (rv_pend) begin
        rvc--;
        if (rvc <= 0) begin mem_rvalid = 1'b1; mem_rdata = rv_data; rv_pend = 0; end
      end else if ($urandom_range(0, 7) == 0) begin
        mem_rvalid = 1'b1;
      end
      if (mem_req) begin
        if (!busy) begin
          busy = 1;
          if (cmd_q.size() == 0) begin
            have = 0; checks++; failures++;
            $display("FAIL mem_req_unexpected got mem_req=1 addr=%h expected no request", mem_addr);
            cur.we = 1'b1; cnt = 0;
          end else begin
            have = 1; cur = cmd_q.pop_front(); cnt = cur.gd;
          end
        end
        if (have) begin
          chk("mem_we", 32'(mem_we), 32'(cur.we));
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_be", 32'(mem_be), 32'(cur.be));
          if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
          chk("req_ready_busy", 32'(req_ready), 32'd0);
        end
        if (cnt == 0) begin
          mem_gnt = 1'b1; busy = 0;
          if (!cur.we) begin rv_pend = 1; rvc = cur.rd; rv_data = cur.rdata; end
        end else begin
          cnt--;
        end
      end else begin
        chk("mem_be_idle", 32'(mem_be), 32'd0);
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected got rsp_valid=1 err=%0b rdata=%h expected no response",
                   rsp_err, rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if (rsp_err !== e.err || rsp_rdata !== e.rdata || $time != e.due) begin
            failures++;
            $display("FAIL rsp got err=%0b rdata=%h t=%0t expected err=%0b rdata=%h t=%0t",
                     rsp_err, rsp_rdata, $time, e.err, e.rdata, e.due);
          end else begin
            $display("rsp t=%0t err=%0b rdata=%h", $time, rsp_err, rsp_rdata);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got no finish expected completion within 2ms");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic        we;
    logic [2:0]  f3;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    txn(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 0, 1, 32'h0, 0);        // sb, immediate grant
    txn(1'b0, 3'b000, 32'h102, 32'h0, 0, 1, 32'h12F4_0000, 0);        // lb
    txn(1'b0, 3'b100, 32'h102, 32'h0, 0, 1, 32'h12F4_0000, 0);        // lbu
    txn(1'b0, 3'b001, 32'h202, 32'h0, 3, 2, 32'h8765_4321, 0);        // lh, late grant
    txn(1'b0, 3'b010, 32'h101, 32'h0, 0, 1, 32'hCAFE_F00D, 0);        // lw misaligned
    txn(1'b1, 3'b011, 32'h400, 32'h1234_5678, 0, 1, 32'h0, 0);        // illegal store
    txn(1'b1, 3'b001, 32'h0FF, 32'hBEEF_7E57, 1, 1, 32'h0, 0);        // sh misaligned
    txn(1'b0, 3'b101, 32'h0FE, 32'h0, 2, 3, 32'h9ABC_DEF0, 0);        // lhu upper lane

    // Reset during WAIT: access is abandoned and the late rvalid must be ignored.
    txn(1'b0, 3'b010, 32'h300, 32'h0, 0, 3, 32'hDEAD_BEEF, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("postrst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      txn(we, f3, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3), $urandom, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
